m5_ddram_arb: RTL

M5_DDRAM_ARB -- requirements
Module: m5_ddram_arb

---
 rtl/m5_ddram_arb.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/m5_ddram_arb.sv
// m5_ddram_arb
// Two-requester byte-access arbiter onto the MiSTer DDR3 Avalon port.
// A ROM/data loader issues byte writes into the loader region at BASE_ADDR,
// and a CPU issues byte reads/writes into the region at BASE_ADDR + CPU_OFS.
// Each access becomes one single-beat 64-bit Avalon transaction with byte
// enables. Ties between requesters are broken round-robin.
//
// Ports
//   clk_sys            sole clock (rising edge)
//   reset              synchronous, active-high reset
//   ld_req/addr/data   loader byte-write request, held until ld_ack
//   ld_ack             one-cycle loader completion pulse
//   cpu_req/we/addr/din CPU byte request (we=1 write), held until cpu_ack
//   cpu_dout/cpu_ack   read byte and one-cycle completion pulse
//   DDRAM_*            MiSTer DDR3 Avalon master port (burst length 1)
module m5_ddram_arb #(
    parameter logic [28:0] BASE_ADDR = 29'h0600_0000,
    parameter logic [28:0] CPU_OFS   = 29'h0010_0000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ld_req,
    input  logic [24:0] ld_addr,
    input  logic [7:0]  ld_data,
    output logic        ld_ack,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [16:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        DDRAM_CLK,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR       = 3'd1,
        ST_RD_ISSUE = 3'd2,
        ST_RD_WAIT  = 3'd3,
        ST_DISCARD  = 3'd4
    } state_t;

    state_t      state_r;
    logic        last_cpu_r;    // 1: CPU was granted last, so loader wins a tie
    logic        owner_cpu_r;   // requester of the transaction in flight
    logic [2:0]  lane_r;        // byte lane of the transaction in flight
    logic        rd_r;
    logic        we_r;
    logic [7:0]  be_r;
    logic [28:0] addr_r;
    logic [63:0] din_r;
    logic        ld_ack_r;
    logic        cpu_ack_r;
    logic [7:0]  cpu_dout_r;

    logic [28:0] ld_word_s;
    logic [28:0] cpu_word_s;
    logic        grant_ld_s;
    logic        grant_cpu_s;
    logic        rd_accepted_s;

    // Extract one byte lane from a 64-bit memory word.
    function automatic logic [7:0] lane_byte(input logic [63:0] word, input logic [2:0] lane);
        lane_byte = word[{lane, 3'b000} +: 8];
    endfunction

    // Word addresses wrap modulo 2^29 through the natural 29-bit sum.
    assign ld_word_s  = BASE_ADDR + {7'd0, ld_addr[24:3]};
    assign cpu_word_s = BASE_ADDR + CPU_OFS + {15'd0, cpu_addr[16:3]};

    // A read is accepted by the controller on an RD_ISSUE cycle with BUSY low.
    assign rd_accepted_s = (state_r == ST_RD_ISSUE) && !DDRAM_BUSY;

    assign DDRAM_CLK      = clk_sys;
    assign DDRAM_BURSTCNT = 8'd1;
    assign DDRAM_ADDR     = addr_r;
    assign DDRAM_DIN      = din_r;
    assign DDRAM_BE       = be_r;
    assign DDRAM_RD       = rd_r;
    assign DDRAM_WE       = we_r;
    assign ld_ack         = ld_ack_r;
    assign cpu_ack        = cpu_ack_r;
    assign cpu_dout       = cpu_dout_r;

    // Grant selection: only in IDLE and never while an ack is being pulsed,
    // because the acked requester still shows req high during that cycle.
    always_comb begin
        grant_ld_s  = 1'b0;
        grant_cpu_s = 1'b0;
        if ((state_r == ST_IDLE) && !ld_ack_r && !cpu_ack_r) begin
            if (ld_req && cpu_req) begin
                grant_ld_s  = last_cpu_r;
                grant_cpu_s = !last_cpu_r;
            end else begin
                grant_ld_s  = ld_req;
                grant_cpu_s = cpu_req;
            end
        end else begin
            grant_ld_s  = 1'b0;
            grant_cpu_s = 1'b0;
        end
    end

    // Arbiter FSM with registered Avalon command and ack outputs.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            rd_r        <= 1'b0;
            we_r        <= 1'b0;
            be_r        <= 8'hFF;
            addr_r      <= 29'd0;
            din_r       <= 64'd0;
            ld_ack_r    <= 1'b0;
            cpu_ack_r   <= 1'b0;
            cpu_dout_r  <= 8'h00;
            last_cpu_r  <= 1'b1;
            owner_cpu_r <= 1'b0;
            lane_r      <= 3'd0;
            // A read already accepted by the controller will still return
            // data; swallow it so it cannot complete a later request.
            if (rd_accepted_s || (state_r == ST_RD_WAIT) || (state_r == ST_DISCARD)) begin
                state_r <= ST_DISCARD;
            end else begin
                state_r <= ST_IDLE;
            end
        end else begin
            ld_ack_r  <= 1'b0;
            cpu_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (grant_ld_s) begin
                        last_cpu_r  <= 1'b0;
                        owner_cpu_r <= 1'b0;
                        lane_r      <= ld_addr[2:0];
                        addr_r      <= ld_word_s;
                        din_r       <= {8{ld_data}};
                        be_r        <= 8'd1 << ld_addr[2:0];
                        we_r        <= 1'b1;
                        state_r     <= ST_WR;
                    end else if (grant_cpu_s) begin
                        last_cpu_r  <= 1'b1;
                        owner_cpu_r <= 1'b1;
                        lane_r      <= cpu_addr[2:0];
                        addr_r      <= cpu_word_s;
                        if (cpu_we) begin
                            din_r   <= {8{cpu_din}};
                            be_r    <= 8'd1 << cpu_addr[2:0];
                            we_r    <= 1'b1;
                            state_r <= ST_WR;
                        end else begin
                            be_r    <= 8'hFF;
                            rd_r    <= 1'b1;
                            state_r <= ST_RD_ISSUE;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WR: begin
                    if (!DDRAM_BUSY) begin
                        we_r <= 1'b0;
                        if (owner_cpu_r) begin
                            cpu_ack_r <= 1'b1;
                        end else begin
                            ld_ack_r <= 1'b1;
                        end
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WR;
                    end
                end
                ST_RD_ISSUE: begin
                    if (!DDRAM_BUSY) begin
                        rd_r    <= 1'b0;
                        state_r <= ST_RD_WAIT;
                    end else begin
                        state_r <= ST_RD_ISSUE;
                    end
                end
                ST_RD_WAIT: begin
                    if (DDRAM_DOUT_READY) begin
                        cpu_dout_r <= lane_byte(DDRAM_DOUT, lane_r);
                        cpu_ack_r  <= 1'b1;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r <= ST_RD_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (DDRAM_DOUT_READY) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DISCARD;
                    end
                end
                default: begin
                    rd_r    <= 1'b0;
                    we_r    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
